usb_desc_streamer: RTL and testbench

Parametrised descriptor-transfer engine for the control-endpoint IN data stage. It accepts a request naming a descriptor's ROM address and length plus the host's wLength. It clamps the transfer length, reads bytes from the descriptor ROM, and streams them to the packet transmitter in max-packet-size chunks. It retransmits a packet on NAK and appends a zero-length packet when USB rules require one. It sits between the standard-request decoder (which owns the address/length table) and the descriptor ROM / TX packet path.

---
 rtl/usb_desc_streamer.sv | 199 +++++++++++++++++++
 tb/tb_usb_desc_streamer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_desc_streamer.sv
// usb_desc_streamer
//
// Streams a descriptor out of the descriptor ROM for the IN data stage of a
// control transfer. The transfer length is clamped to the host's wLength and
// sent in MPS-byte packets. A packet is resent on NAK, and a trailing
// zero-length packet is added when the transfer ends on a packet boundary short
// of wLength (or is empty).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_addr              descriptor start address in ROM
//   req_desc_len          descriptor length
//   req_wlength           host wLength
//   descrom_raddr_o       ROM read address (base + current offset, wraps)
//   descrom_rdata_i       ROM data, combinational from descrom_raddr_o
//   tx_valid/tx_ready     byte/ZLP handshake towards the packet transmitter
//   tx_data               payload byte (0 when not sending payload)
//   tx_last               final byte of the packet, or ZLP marker
//   tx_zlp                current beat is a zero-length packet
//   pkt_ack, pkt_nak      host response to the last packet (pulses)
//   abort                 new SETUP / bus reset, cancels the transfer
//   busy                  transfer in progress
//   done                  1-cycle pulse after the final packet is ACKed
module usb_desc_streamer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned MPS    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_desc_len,
    input  logic [LEN_W-1:0]  req_wlength,
    output logic [ADDR_W-1:0] descrom_raddr_o,
    input  logic [7:0]        descrom_rdata_i,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic              tx_zlp,
    input  logic              pkt_ack,
    input  logic              pkt_nak,
    input  logic              abort,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PW = $clog2(MPS);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSend    = 2'd1;
    localparam logic [1:0] StZlp     = 2'd2;
    localparam logic [1:0] StWaitAck = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  total_q, total_d;
    logic              zlp_need_q, zlp_need_d;
    logic [LEN_W-1:0]  offset_q, offset_d;   // bytes confirmed by ACK
    logic [LEN_W-1:0]  cur_q, cur_d;         // byte offset being sent
    logic [PW-1:0]     pcnt_q, pcnt_d;       // bytes already sent in this packet
    logic              last_zlp_q, last_zlp_d;
    logic              done_q, done_d;

    logic [LEN_W-1:0]  req_total;
    logic              req_zlp_need;
    logic              send_last;

    assign req_total    = (req_desc_len < req_wlength) ? req_desc_len : req_wlength;
    // A short transfer ending exactly on a packet boundary needs a ZLP so the
    // host sees the end of the data stage.
    assign req_zlp_need = (req_total == '0) ||
                          ((req_total < req_wlength) && (req_total[PW-1:0] == '0));

    assign send_last = (pcnt_q == PW'(MPS - 1)) || (cur_q == total_q - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        total_d    = total_q;
        zlp_need_d = zlp_need_q;
        offset_d   = offset_q;
        cur_d      = cur_q;
        pcnt_d     = pcnt_q;
        last_zlp_d = last_zlp_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d    = StIdle;
            base_d     = '0;
            total_d    = '0;
            zlp_need_d = 1'b0;
            offset_d   = '0;
            cur_d      = '0;
            pcnt_d     = '0;
            last_zlp_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        base_d     = req_addr;
                        total_d    = req_total;
                        zlp_need_d = req_zlp_need;
                        offset_d   = '0;
                        cur_d      = '0;
                        pcnt_d     = '0;
                        last_zlp_d = 1'b0;
                        state_d    = (req_total != '0) ? StSend : StZlp;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        cur_d = cur_q + LEN_W'(1);
                        if (send_last) begin
                            pcnt_d     = '0;
                            last_zlp_d = 1'b0;
                            state_d    = StWaitAck;
                        end else begin
                            pcnt_d = pcnt_q + PW'(1);
                        end
                    end
                end
                StZlp: begin
                    if (tx_ready) begin
                        last_zlp_d = 1'b1;
                        state_d    = StWaitAck;
                    end
                end
                StWaitAck: begin
                    // NAK wins over a simultaneous ACK: rewind to the last
                    // acknowledged offset and resend the same packet.
                    if (pkt_nak) begin
                        cur_d   = offset_q;
                        pcnt_d  = '0;
                        state_d = last_zlp_q ? StZlp : StSend;
                    end else if (pkt_ack) begin
                        offset_d = cur_q;
                        if (cur_q < total_q) begin
                            state_d = StSend;
                        end else if (zlp_need_q && !last_zlp_q) begin
                            state_d = StZlp;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            total_q    <= '0;
            zlp_need_q <= 1'b0;
            offset_q   <= '0;
            cur_q      <= '0;
            pcnt_q     <= '0;
            last_zlp_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            total_q    <= total_d;
            zlp_need_q <= zlp_need_d;
            offset_q   <= offset_d;
            cur_q      <= cur_d;
            pcnt_q     <= pcnt_d;
            last_zlp_q <= last_zlp_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = done_q;
        tx_valid  = (state_q == StSend) || (state_q == StZlp);
        tx_zlp    = (state_q == StZlp);
        tx_last   = 1'b0;
        tx_data   = 8'h00;
        if (state_q == StSend) begin
            tx_last = send_last;
            tx_data = descrom_rdata_i;
        end else if (state_q == StZlp) begin
            tx_last = 1'b1;
        end
    end

    // Address wraps silently at the top of the ROM.
    assign descrom_raddr_o = base_q + ADDR_W'(cur_q);

endmodule

// File: tb/tb_usb_desc_streamer.sv
module tb_usb_desc_streamer;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int MPS = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LEN_W-1:0]  req_desc_len = '0;
    logic [LEN_W-1:0]  req_wlength = '0;
    logic [ADDR_W-1:0] descrom_raddr_o;
    logic [7:0]        descrom_rdata_i;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_last;
    logic              tx_zlp;
    logic              pkt_ack = 1'b0;
    logic              pkt_nak = 1'b0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    usb_desc_streamer #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W),
        .MPS   (MPS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_desc_len   (req_desc_len),
        .req_wlength    (req_wlength),
        .descrom_raddr_o(descrom_raddr_o),
        .descrom_rdata_i(descrom_rdata_i),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_last        (tx_last),
        .tx_zlp         (tx_zlp),
        .pkt_ack        (pkt_ack),
        .pkt_nak        (pkt_nak),
        .abort          (abort),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] * 8'd3) ^ 8'h5A;
    endfunction

    assign descrom_rdata_i = rom_fn(descrom_raddr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] dlen;
        logic [15:0] wl;
        int exp_bytes;   // payload bytes ACKed by the host
        int exp_zlps;    // ZLPs ACKed by the host
        int nak_at;      // packet index NAKed once (-1: none)
        int both_at;     // packet index given ACK+NAK together once
        int abort_at;    // abort after this many bytes sent (-1: none)
        int stall_pct;
    } vec_t;

    vec_t vecs[$];

    task automatic recover();
        tx_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Drives one transfer as the host/transmitter and checks every beat
    // against the expected packet list derived from the transfer rules.
    task automatic do_xfer(input vec_t v, input int nak_pct,
                           output int got_bytes, output int got_zlps);
        int total;
        int starts[$];
        int lens[$];
        int off;
        int n;
        int sent;
        logic [7:0] s_data;
        logic s_last, s_zlp, stalled;
        bit nak, plain_nak, both;
        got_bytes = 0;
        got_zlps = 0;
        sent = 0;
        total = (v.dlen < v.wl) ? int'(v.dlen) : int'(v.wl);
        off = 0;
        while (off < total) begin
            n = (total - off > MPS) ? MPS : total - off;
            starts.push_back(off);
            lens.push_back(n);
            off += n;
        end
        if (total == 0 || (total < int'(v.wl) && total % MPS == 0)) begin
            starts.push_back(total);
            lens.push_back(0);
        end

        check("req_ready before request", req_ready, 1);
        req_valid = 1'b1;
        req_addr = v.addr;
        req_desc_len = v.dlen;
        req_wlength = v.wl;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 16'($urandom);
        req_desc_len = 16'($urandom);
        req_wlength = 16'($urandom);

        for (int p = 0; p < lens.size(); p++) begin
            int attempt = 0;
            forever begin
                int idx = 0;
                int cyc = 0;
                bit fin = 0;
                stalled = 1'b0;
                while (!fin) begin
                    if (tx_valid !== 1'b1) begin
                        check("tx_valid during packet", tx_valid, 1);
                        recover();
                        return;
                    end
                    if (stalled) begin
                        check("stall tx_data stable", tx_data, s_data);
                        check("stall tx_last stable", tx_last, s_last);
                        check("stall tx_zlp stable", tx_zlp, s_zlp);
                    end
                    if (v.abort_at >= 0 && sent == v.abort_at) begin
                        tx_ready = 1'b0;
                        abort = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        check("abort tx_valid", tx_valid, 0);
                        check("abort req_ready", req_ready, 1);
                        check("abort busy", busy, 0);
                        check("abort done", done, 0);
                        @(negedge clk);
                        check("abort no late done", done, 0);
                        return;
                    end
                    tx_ready = ($urandom_range(0, 99) >= v.stall_pct);
                    if (tx_ready) begin
                        if (lens[p] == 0) begin
                            check("zlp tx_zlp", tx_zlp, 1);
                            check("zlp tx_last", tx_last, 1);
                            check("zlp tx_data", tx_data, 0);
                            fin = 1;
                        end else begin
                            check("tx_data", tx_data, rom_fn(16'(v.addr + starts[p] + idx)));
                            check("tx_zlp payload", tx_zlp, 0);
                            check("tx_last", tx_last, 32'(idx == lens[p] - 1));
                            fin = (idx == lens[p] - 1);
                            idx++;
                            sent++;
                        end
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        s_data = tx_data;
                        s_last = tx_last;
                        s_zlp = tx_zlp;
                    end
                    @(negedge clk);
                    cyc++;
                    if (cyc > 5000) begin
                        check("packet timeout", 0, 1);
                        recover();
                        return;
                    end
                end
                tx_ready = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    check("wait_ack tx_valid idle", tx_valid, 0);
                    @(negedge clk);
                end
                check("wait_ack busy", busy, 1);
                check("wait_ack tx_valid", tx_valid, 0);
                plain_nak = (p == v.nak_at && attempt == 0) ||
                            ($urandom_range(0, 99) < nak_pct && attempt < 3);
                both = (p == v.both_at && attempt == 0);
                nak = plain_nak || both;
                pkt_nak = nak;
                pkt_ack = both || !nak;
                @(negedge clk);
                pkt_ack = 1'b0;
                pkt_nak = 1'b0;
                if (nak) begin
                    check("done after nak", done, 0);
                    attempt++;
                    continue;
                end
                if (lens[p] == 0) got_zlps++;
                else got_bytes += lens[p];
                if (p == lens.size() - 1) begin
                    check("final done", done, 1);
                    check("final req_ready", req_ready, 1);
                    check("final busy", busy, 0);
                    check("final tx_valid", tx_valid, 0);
                    @(negedge clk);
                    check("done one cycle", done, 0);
                end else begin
                    check("done early", done, 0);
                end
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " tx_valid"}, tx_valid, 0);
        check({tag, " tx_last"}, tx_last, 0);
        check({tag, " tx_zlp"}, tx_zlp, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " raddr"}, descrom_raddr_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, z;
        vec_t v;

        //             addr      dlen     wl       bytes zlps nak both abort stall
        vecs.push_back('{16'd0,   16'd18,  16'd64,  18,  0,  -1, -1, -1,  0});
        vecs.push_back('{16'd28,  16'd70,  16'd255, 70,  0,  -1, -1, -1,  0});
        vecs.push_back('{16'd0,   16'd64,  16'd255, 64,  1,  -1, -1, -1,  0});
        vecs.push_back('{16'd0,   16'd64,  16'd64,  64,  0,  -1, -1, -1,  0});
        vecs.push_back('{16'd28,  16'd70,  16'd255, 70,  0,   1, -1, -1,  0});
        vecs.push_back('{16'd28,  16'd70,  16'd255, 70,  0,  -1,  0, -1,  0});
        vecs.push_back('{16'd5,   16'd0,   16'd10,  0,   1,  -1, -1, -1,  0});
        vecs.push_back('{16'd100, 16'd300, 16'd200, 200, 0,  -1, -1, -1,  0});
        vecs.push_back('{16'd0,   16'd128, 16'd200, 128, 1,  -1, -1, -1,  0});
        vecs.push_back('{16'd0,   16'd64,  16'd255, 0,   0,  -1, -1, 30,  0});
        vecs.push_back('{16'd0,   16'd10,  16'd0,   0,   1,  -1, -1, -1,  0});
        vecs.push_back('{16'hFFF0, 16'd40, 16'd40,  40,  0,  -1, -1, -1,  0});
        vecs.push_back('{16'd28,  16'd70,  16'd255, 70,  0,  -1, -1, -1, 40});
        vecs.push_back('{16'd7,   16'd64,  16'd100, 64,  1,   1, -1, -1, 30});

        repeat (3) @(negedge clk);
        check_reset_outputs("in reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after reset");

        // ACK/NAK while idle must be ignored.
        pkt_ack = 1'b1;
        pkt_nak = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        pkt_nak = 1'b0;
        check("idle ack ignored busy", busy, 0);
        check("idle ack ignored done", done, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_xfer(vecs[i], 0, b, z);
            check($sformatf("vec%0d bytes", i), b, vecs[i].exp_bytes);
            check($sformatf("vec%0d zlps", i), z, vecs[i].exp_zlps);
            @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            int tot;
            v.addr = 16'($urandom);
            v.dlen = ($urandom_range(0, 3) == 0) ? 16'(64 * $urandom_range(0, 3))
                                                  : 16'($urandom_range(0, 200));
            case ($urandom_range(0, 3))
                0: v.wl = v.dlen;
                1: v.wl = v.dlen + 16'($urandom_range(1, 50));
                2: v.wl = 16'($urandom_range(0, 200));
                default: v.wl = 16'(64 * $urandom_range(0, 4));
            endcase
            v.nak_at = -1;
            v.both_at = ($urandom_range(0, 4) == 0) ? 0 : -1;
            v.abort_at = -1;
            v.stall_pct = $urandom_range(0, 50);
            tot = (v.dlen < v.wl) ? int'(v.dlen) : int'(v.wl);
            v.exp_bytes = tot;
            v.exp_zlps = (tot == 0 || (tot < int'(v.wl) && tot % MPS == 0)) ? 1 : 0;
            do_xfer(v, 25, b, z);
            check($sformatf("rand%0d bytes", i), b, v.exp_bytes);
            check($sformatf("rand%0d zlps", i), z, v.exp_zlps);
        end

        // Asynchronous reset in the middle of a packet.
        req_valid = 1'b1;
        req_addr = 16'd0;
        req_desc_len = 16'd64;
        req_wlength = 16'd255;
        @(negedge clk);
        req_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("pre-reset busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset done", done, 0);
        check("post-reset req_ready", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
